ysyx_22041211_ifu: RTL and testbench

Instruction fetch unit between the CPU core's decode stage and the instruction SRAM. It owns the fetch PC and issues one read request at a time to the instruction SRAM. It buffers the returned word and hands it to decode over a valid/ready handshake. It applies redirects from execute and stops fetching on halt (ebreak).

---
 rtl/ysyx_22041211_ifu_pkg.sv | 20 ++
 rtl/ysyx_22041211_ifu_if.sv | 25 ++
 rtl/ysyx_22041211_ifu_buf.sv | 46 ++++
 rtl/ysyx_22041211_ifu.sv | 127 ++++++++++++
 tb/tb_ysyx_22041211_ifu.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// and the instruction-alignment helper.
package ysyx_22041211_ifu_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE,
        IFU_REQ,
        IFU_WAIT,
        IFU_HOLD,
        IFU_HALT
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC    = 32'h8000_0000;
    localparam logic [1:0]  INST_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return (lo & INST_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041211_ifu_if.sv
// Fetch-side bus bundle: instruction SRAM request/response plus the
// valid/ready instruction handoff to decode.
interface ysyx_22041211_ifu_if #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
);
    logic                imem_req_o;
    logic [ADDR_LEN-1:0] imem_addr_o;
    logic                imem_rvalid_i;
    logic [DATA_LEN-1:0] imem_rdata_i;
    logic                inst_valid_o;
    logic [DATA_LEN-1:0] inst_o;
    logic [ADDR_LEN-1:0] inst_pc_o;
    logic                inst_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_rvalid_i, imem_rdata_i, inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_rvalid_i, imem_rdata_i, inst_ready_i
    );
endinterface

// File: rtl/ysyx_22041211_ifu_buf.sv
// One-entry instruction holding register. Contents stay stable while valid;
// flush drops the entry, a valid&ready handoff empties it.
module ysyx_22041211_ifu_buf #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [DATA_LEN-1:0] data_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                ready_i,
    input  logic                flush_i,
    output logic                valid_o,
    output logic [DATA_LEN-1:0] data_o,
    output logic [ADDR_LEN-1:0] pc_o
);
    logic                valid_q, valid_d;
    logic [DATA_LEN-1:0] data_q;
    logic [ADDR_LEN-1:0] pc_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_i)                 valid_d = 1'b0;
        else if (load_i)             valid_d = 1'b1;
        else if (valid_q && ready_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                data_q <= data_i;
                pc_q   <= pc_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one SRAM read in flight,
// hands words to decode, and honours redirects and halt.
module ysyx_22041211_ifu
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int          DATA_LEN = 32,
    parameter int          ADDR_LEN = 32,
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_22041211_ifu_if.master bus,
    input  logic                redirect_valid_i,
    input  logic [ADDR_LEN-1:0] redirect_pc_i,
    input  logic                halt_i,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic                misalign_o
);
    ifu_state_e          state_q, state_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic                kill_q, kill_d;
    logic                hpend_q, hpend_d;
    logic                mis_q, mis_d;
    logic                buf_load, buf_flush;
    logic                redir, bad_tgt, stop_new;
    logic                buf_valid;
    logic [DATA_LEN-1:0] buf_data;
    logic [ADDR_LEN-1:0] buf_pc;

    assign redir    = redirect_valid_i;
    assign bad_tgt  = redir && is_misaligned(redirect_pc_i[1:0]);
    assign stop_new = halt_i || bad_tgt;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        hpend_d   = hpend_q;
        mis_d     = mis_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;

        // Redirect target is tracked in every live state, even when halt wins.
        if (state_q != IFU_HALT && redir) begin
            pc_d = redirect_pc_i;
            if (bad_tgt) mis_d = 1'b1;
        end

        case (state_q)
            IFU_IDLE: state_d = stop_new ? IFU_HALT : IFU_REQ;
            IFU_REQ: begin
                state_d = IFU_WAIT;
                if (redir)    kill_d  = 1'b1;
                if (stop_new) hpend_d = 1'b1;
            end
            IFU_WAIT: begin
                if (bus.imem_rvalid_i) begin
                    // A response that lost its PC (redirect/halt) is dropped.
                    if (kill_q || redir || hpend_q || stop_new) begin
                        kill_d  = 1'b0;
                        state_d = (hpend_q || stop_new) ? IFU_HALT : IFU_REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = IFU_HOLD;
                    end
                end else begin
                    if (redir)    kill_d  = 1'b1;
                    if (stop_new) hpend_d = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (bus.inst_ready_i && !redir) pc_d = pc_q + ADDR_LEN'(4);
                if (stop_new) begin
                    state_d   = IFU_HALT;
                    buf_flush = 1'b1;
                end else if (redir) begin
                    state_d   = IFU_REQ;
                    buf_flush = 1'b1;
                end else if (bus.inst_ready_i) begin
                    state_d = IFU_REQ;
                end
            end
            IFU_HALT: state_d = IFU_HALT;
            default:  state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IFU_IDLE;
            pc_q    <= ADDR_LEN'(RESET_PC);
            kill_q  <= 1'b0;
            hpend_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            hpend_q <= hpend_d;
            mis_q   <= mis_d;
        end
    end

    ysyx_22041211_ifu_buf #(
        .DATA_LEN(DATA_LEN),
        .ADDR_LEN(ADDR_LEN)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .load_i (buf_load),
        .data_i (bus.imem_rdata_i),
        .pc_i   (pc_q),
        .ready_i(bus.inst_ready_i),
        .flush_i(buf_flush),
        .valid_o(buf_valid),
        .data_o (buf_data),
        .pc_o   (buf_pc)
    );

    assign bus.imem_req_o   = (state_q == IFU_REQ);
    assign bus.imem_addr_o  = pc_q;
    assign bus.inst_valid_o = buf_valid;
    assign bus.inst_o       = buf_data;
    assign bus.inst_pc_o    = buf_pc;
    assign pc_o             = pc_q;
    assign misalign_o       = mis_q;
endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Directed bench for the fetch unit: handshake timing, backpressure,
// redirect kill, misalign, halt, async reset and PC wrap.
module tb_ysyx_22041211_ifu;
    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] pc;
    logic        misalign;
    int          npass = 0;
    int          ntot  = 0;

    ysyx_22041211_ifu_if #(.DATA_LEN(32), .ADDR_LEN(32)) bus ();

    ysyx_22041211_ifu #(.DATA_LEN(32), .ADDR_LEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .halt_i          (halt),
        .pc_o            (pc),
        .misalign_o      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0; bus.inst_ready_i = 1'b0;
        step(); step();
        chk("rst_req",   {31'b0, bus.imem_req_o},   32'd0);
        chk("rst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("rst_inst",  bus.inst_o,                32'd0);
        chk("rst_ipc",   bus.inst_pc_o,             32'd0);
        chk("rst_pc",    pc,                        32'h8000_0000);
        chk("rst_mis",   {31'b0, misalign},         32'd0);

        // basic fetch, 1-cycle memory, ready=1
        rst = 1'b1;
        step();                                   // IDLE -> REQ
        chk("t1_req0",  {31'b0, bus.imem_req_o}, 32'd1);
        chk("t1_addr0", bus.imem_addr_o,          32'h8000_0000);
        bus.inst_ready_i = 1'b1;
        step();                                   // REQ -> WAIT
        chk("t1_req_pulse", {31'b0, bus.imem_req_o}, 32'd0);
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0000_0013;
        step();                                   // WAIT -> HOLD
        bus.imem_rvalid_i = 1'b0;
        chk("t1_valid", {31'b0, bus.inst_valid_o}, 32'd1);
        chk("t1_inst",  bus.inst_o,                32'h0000_0013);
        chk("t1_ipc",   bus.inst_pc_o,             32'h8000_0000);
        step();                                   // handoff -> REQ
        chk("t1_valid_clr", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("t1_req1",  {31'b0, bus.imem_req_o},   32'd1);
        chk("t1_addr1", bus.imem_addr_o,            32'h8000_0004);

        // backpressure for 5 cycles
        bus.inst_ready_i = 1'b0;
        step();
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0010_0093;
        step();
        bus.imem_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", {31'b0, bus.inst_valid_o}, 32'd1);
            chk("t2_hold_inst",  bus.inst_o,                32'h0010_0093);
            chk("t2_hold_ipc",   bus.inst_pc_o,             32'h8000_0004);
            chk("t2_hold_noreq", {31'b0, bus.imem_req_o},   32'd0);
            step();
        end
        chk("t2_hold_last", {31'b0, bus.inst_valid_o}, 32'd1);
        bus.inst_ready_i = 1'b1;
        step();
        bus.inst_ready_i = 1'b0;
        chk("t2_valid_clr", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("t2_req",  {31'b0, bus.imem_req_o},        32'd1);
        chk("t2_addr", bus.imem_addr_o,                32'h8000_0008);

        // redirect during WAIT kills the in-flight word
        step();                                   // REQ -> WAIT
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        step();                                   // kill set
        redirect_valid = 1'b0;
        chk("t3_pc",    pc,                        32'h8000_0100);
        chk("t3_noreq", {31'b0, bus.imem_req_o},   32'd0);
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF; bus.inst_ready_i = 1'b1;
        step();                                   // discarded -> REQ
        bus.imem_rvalid_i = 1'b0;
        chk("t3_novalid", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("t3_req",     {31'b0, bus.imem_req_o},   32'd1);
        chk("t3_addr",    bus.imem_addr_o,           32'h8000_0100);
        step();
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0000_0013;
        step();
        bus.imem_rvalid_i = 1'b0;
        chk("t3_inst", bus.inst_o,    32'h0000_0013);
        chk("t3_ipc",  bus.inst_pc_o, 32'h8000_0100);
        step();
        bus.inst_ready_i = 1'b0;
        chk("t3_addr2", bus.imem_addr_o, 32'h8000_0104);

        // misaligned redirect while a request is issued
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        chk("t4_mis", {31'b0, misalign}, 32'd1);
        chk("t4_pc",  pc,                32'h8000_0102);
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h1111_1111;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.imem_rvalid_i = i[0]; bus.inst_ready_i = ~i[0];
            step();
            chk("t4_noreq",   {31'b0, bus.imem_req_o},   32'd0);
            chk("t4_novalid", {31'b0, bus.inst_valid_o}, 32'd0);
        end
        chk("t4_mis_sticky", {31'b0, misalign}, 32'd1);

        // halt during WAIT
        bus.imem_rvalid_i = 1'b0; bus.inst_ready_i = 1'b0;
        rst = 1'b0;
        step();
        chk("t5_mis_rst", {31'b0, misalign}, 32'd0);
        rst = 1'b1;
        step();
        chk("t5_req", {31'b0, bus.imem_req_o}, 32'd1);
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0000_0013; bus.inst_ready_i = 1'b1;
        step();
        chk("t5_discard", {31'b0, bus.inst_valid_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.imem_rvalid_i = i[0]; bus.inst_ready_i = i[1];
            step();
            chk("t5_noreq",   {31'b0, bus.imem_req_o},   32'd0);
            chk("t5_novalid", {31'b0, bus.inst_valid_o}, 32'd0);
        end

        // async reset in the middle of WAIT
        bus.imem_rvalid_i = 1'b0; bus.inst_ready_i = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();                                   // REQ 8000_0000
        step();                                   // WAIT
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0000_0013;
        step();                                   // HOLD
        bus.imem_rvalid_i = 1'b0; bus.inst_ready_i = 1'b1;
        step();                                   // REQ 8000_0004
        bus.inst_ready_i = 1'b0;
        step();                                   // WAIT
        chk("t5b_pre_pc", pc, 32'h8000_0004);
        #2;
        rst = 1'b0;
        #1;
        chk("t5b_req",   {31'b0, bus.imem_req_o},   32'd0);
        chk("t5b_valid", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("t5b_inst",  bus.inst_o,                32'd0);
        chk("t5b_ipc",   bus.inst_pc_o,             32'd0);
        chk("t5b_pc",    pc,                        32'h8000_0000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // PC wrap at the top of the address space
        step();                                   // REQ 8000_0000
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();                                   // WAIT, killed
        redirect_valid = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
        step();                                   // discard -> REQ
        bus.imem_rvalid_i = 1'b0;
        chk("t6_req",  {31'b0, bus.imem_req_o}, 32'd1);
        chk("t6_addr", bus.imem_addr_o,          32'hFFFF_FFFC);
        step();
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0000_0073;
        step();
        bus.imem_rvalid_i = 1'b0;
        chk("t6_inst", bus.inst_o,    32'h0000_0073);
        chk("t6_ipc",  bus.inst_pc_o, 32'hFFFF_FFFC);
        bus.inst_ready_i = 1'b1;
        step();
        bus.inst_ready_i = 1'b0;
        chk("t6_wrap_req",  {31'b0, bus.imem_req_o}, 32'd1);
        chk("t6_wrap_addr", bus.imem_addr_o,          32'h0000_0000);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
